// File: rtl/usb_pkg.sv
// Shared USB definitions for the bitstream encoder/decoder pair.
//   pkt_type_t  : packet class handed to the ProtocolFSM
//   dec_state_t : bs_decoder FSM states (also exported on its debug port)
//   *_BITS      : packet lengths including the PID byte, excluding SYNC
//   SYNC        : SYNC pattern in arrival order, first bit = MSB
package usb_pkg;

  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_DATA   = 2'b01,
    PKT_TOKEN  = 2'b10,
    PKT_HSHAKE = 2'b11
  } pkt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PID      = 3'd1,
    ST_BODY     = 3'd2,
    ST_WAIT_EOP = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_HOLD     = 3'd5
  } dec_state_t;

  localparam int DATA_BITS   = 88;
  localparam int TOKEN_BITS  = 24;
  localparam int HSHAKE_BITS = 8;
  localparam logic [7:0] SYNC = 8'b0000_0001;

  // A PID carries its own check: the upper nibble is the complement of the lower.
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/sipo_register.sv
// Serial-in / parallel-out shift register, MSB-first.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over en_i)
//   en_i       : shift d_i into bit 0, older bits move toward the MSB
//   d_i        : serial data
//   q_o        : parallel contents
module sipo_register #(
  parameter int W = 88
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {q_q[W-2:0], d_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bs_decoder.sv
// Receive bitstream decoder: hunts for SYNC on the unstuffed serial stream,
// checks the PID, deserialises handshake/token/data packets and presents the
// fields to the ProtocolFSM until acknowledged. No CRC checking here.
//   clk, rst_n : clock, asynchronous active-low reset
//   s_in       : serial bit, meaningful only when s_valid=1
//   s_valid    : s_in is a real (non-stuffed) bit this cycle
//   eop        : end-of-packet pulse; wins over a coincident s_valid
//   pkt_ack    : consumer has taken the packet (only honoured in HOLD)
//   pkt_valid  : fields valid, held until pkt_ack
//   pkt_type   : 00 none, 01 data, 10 token, 11 handshake
//   hshake     : PID byte of a handshake packet
//   token      : {PID, addr, endp, crc5}
//   data       : {PID, payload, crc16}
//   pkt_err    : one-cycle pulse, the cycle after a malformed packet is seen
//   busy       : FSM is not in IDLE
//   dbg_state  : current FSM state
//
// Handshake: pkt_valid rises the cycle after eop and stays high with all fields
// frozen; the cycle after pkt_valid && pkt_ack is sampled, pkt_valid drops.
module bs_decoder
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_PAT = SYNC,
  parameter int         CNT_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_in,
  input  logic              s_valid,
  input  logic              eop,
  input  logic              pkt_ack,
  output logic              pkt_valid,
  output logic [1:0]        pkt_type,
  output logic [7:0]        hshake,
  output logic [23:0]       token,
  output logic [87:0]       data,
  output logic              pkt_err,
  output logic              busy,
  output dec_state_t        dbg_state
);

  dec_state_t       state_q, state_d;
  pkt_type_t        cur_q, cur_d;       // type decoded from the PID
  pkt_type_t        ptype_q, ptype_d;   // type presented on the output
  logic [7:0]       win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       hshake_q, hshake_d;
  logic [23:0]      token_q, token_d;
  logic [87:0]      data_q, data_d;

  logic             sr_clr, sr_en;
  logic [87:0]      sr_q;
  logic [7:0]       win_next;
  logic [7:0]       pid_byte;
  logic [CNT_W-1:0] last_idx;

  sipo_register #(.W(DATA_BITS)) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sr_clr),
    .en_i  (sr_en),
    .d_i   (s_in),
    .q_o   (sr_q)
  );

  // The PID byte is complete in the same cycle its 8th bit arrives.
  assign win_next = {win_q[6:0], s_in};
  assign pid_byte = {sr_q[6:0], s_in};
  assign last_idx = (cur_q == PKT_TOKEN) ? CNT_W'(TOKEN_BITS - 1)
                                         : CNT_W'(DATA_BITS - 1);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptype_d  = ptype_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    hshake_d = hshake_q;
    token_d  = token_q;
    data_d   = data_q;
    sr_clr   = 1'b0;
    sr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (eop) begin
          win_d = 8'hFF;
        end else if (s_valid) begin
          win_d = win_next;
          if (win_next == SYNC_PAT) begin
            state_d = ST_PID;
            cnt_d   = '0;
            sr_clr  = 1'b1;
          end
        end
      end

      ST_PID: begin
        if (eop) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          win_d   = 8'hFF;
        end else if (s_valid) begin
          sr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HSHAKE_BITS - 1)) begin
            if (!pid_ok(pid_byte) || pid_byte[1:0] == 2'b00) begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end else if (pid_byte[1:0] == 2'b10) begin
              cur_d   = PKT_HSHAKE;
              state_d = ST_WAIT_EOP;
            end else if (pid_byte[1:0] == 2'b01) begin
              cur_d   = PKT_TOKEN;
              state_d = ST_BODY;
            end else begin
              cur_d   = PKT_DATA;
              state_d = ST_BODY;
            end
          end
        end
      end

      ST_BODY: begin
        if (eop) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          win_d   = 8'hFF;
        end else if (s_valid) begin
          sr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == last_idx) state_d = ST_WAIT_EOP;
        end
      end

      ST_WAIT_EOP: begin
        if (eop) begin
          case (cur_q)
            PKT_DATA:   data_d   = sr_q;
            PKT_TOKEN:  token_d  = sr_q[TOKEN_BITS-1:0];
            PKT_HSHAKE: hshake_d = sr_q[HSHAKE_BITS-1:0];
            default:    ;
          endcase
          ptype_d = cur_q;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (s_valid) begin
          err_d   = 1'b1;   // overlength packet
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (eop) begin
          state_d = ST_IDLE;
          win_d   = 8'hFF;
        end
      end

      ST_HOLD: begin
        // Incoming traffic is dropped while the consumer owns the packet.
        if (pkt_ack) begin
          valid_d = 1'b0;
          ptype_d = PKT_NONE;
          state_d = ST_IDLE;
          win_d   = 8'hFF;
        end
      end

      default: begin
        state_d = ST_IDLE;
        win_d   = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= PKT_NONE;
      ptype_q  <= PKT_NONE;
      win_q    <= 8'hFF;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      hshake_q <= '0;
      token_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptype_q  <= ptype_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      hshake_q <= hshake_d;
      token_q  <= token_d;
      data_q   <= data_d;
    end
  end

  assign pkt_valid = valid_q;
  assign pkt_type  = ptype_q;
  assign hshake    = hshake_q;
  assign token     = token_q;
  assign data      = data_q;
  assign pkt_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bs_decoder.sv
// Bench for bs_decoder: directed packets, scoreboard queue of expected
// events ({kind, value}; kind 0 = pkt_err, 1 data, 2 token, 3 handshake)
// consumed by an independent monitor.
module tb_bs_decoder;
  import usb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        s_in;
  logic        s_valid;
  logic        eop;
  logic        pkt_ack;
  logic        pkt_valid;
  logic [1:0]  pkt_type;
  logic [7:0]  hshake;
  logic [23:0] token;
  logic [87:0] data;
  logic        pkt_err;
  logic        busy;
  dec_state_t  dbg_state;

  logic [90:0] exp_q[$];
  int          checks;
  int          errors;
  logic        prev_valid;

  bs_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .eop       (eop),
    .pkt_ack   (pkt_ack),
    .pkt_valid (pkt_valid),
    .pkt_type  (pkt_type),
    .hshake    (hshake),
    .token     (token),
    .data      (data),
    .pkt_err   (pkt_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_in    = b;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_in    = 1'b0;
  endtask

  task automatic gap();
    s_valid = 1'b0;
    tick();
  endtask

  // Sends v[n-1:0] MSB first; stall>0 inserts an s_valid=0 cycle every stall bits.
  task automatic send_bits(input logic [87:0] v, input int n, input int stall);
    for (int i = n - 1; i >= 0; i--) begin
      if (stall > 0 && ((n - 1 - i) % stall) == stall - 1) gap();
      send_bit(v[i]);
    end
  endtask

  task automatic send_sync();
    send_bits(88'h01, 8, 0);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    tick();
    eop = 1'b0;
  endtask

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // Called right after send_eop: pkt_valid must already be up, then ack it.
  task automatic take_pkt(input string name);
    chk({name, "_valid"}, 88'(pkt_valid), 88'd1);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    chk({name, "_valid_after_ack"}, 88'(pkt_valid), 88'd0);
    chk({name, "_type_after_ack"}, 88'(pkt_type), 88'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_err) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0][90:88] != 3'd0) begin
          errors++;
          $display("FAIL unexpected_pkt_err got 1 want 0");
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (pkt_valid && !prev_valid) begin
        logic [90:0] e;
        logic [87:0] act;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pkt got type %0d want none", pkt_type);
        end else begin
          e = exp_q.pop_front();
          case (pkt_type)
            2'b01:   act = data;
            2'b10:   act = {64'd0, token};
            2'b11:   act = {80'd0, hshake};
            default: act = '0;
          endcase
          if ({1'b0, pkt_type} !== e[90:88] || act !== e[87:0]) begin
            errors++;
            $display("FAIL pkt_fields got type %0d val %h want type %0d val %h",
                     pkt_type, act, e[90:88], e[87:0]);
          end
        end
      end
    end
    prev_valid = pkt_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;
    rst_n      = 1'b0;
    s_in       = 1'b0;
    s_valid    = 1'b0;
    eop        = 1'b0;
    pkt_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pkt_valid, pkt_type, hshake, token, pkt_err, busy}, 88'd0);
    chk("reset_data", data, 88'd0);
    rst_n = 1'b1;
    tick();

    // Handshake D2, held 5 cycles before ack.
    exp_q.push_back({3'd3, 88'hD2});
    send_sync();
    send_bits(88'hD2, 8, 0);
    send_eop();
    chk("hs_valid_latency", 88'(pkt_valid), 88'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hs_hold_stable", {pkt_valid, pkt_type, hshake}, {77'd0, 1'b1, 2'b11, 8'hD2});
    end
    take_pkt("hs");
    chk("hs_field_kept", 88'(hshake), 88'hD2);

    // Token OUT addr 5 endp 1.
    exp_q.push_back({3'd2, 88'hE10A2A});
    send_sync();
    send_bits(88'hE10A2A, 24, 0);
    send_eop();
    take_pkt("tok");

    // Data packet with periodic stalls.
    exp_q.push_back({3'd1, {8'hC3, 64'h0123456789ABCDEF, 16'hBEEF}});
    send_sync();
    send_bits({8'hC3, 64'h0123456789ABCDEF, 16'hBEEF}, 88, 6);
    send_eop();
    take_pkt("data");

    // Bad PID check.
    exp_q.push_back({3'd0, 88'd0});
    send_sync();
    send_bits(88'hD3, 8, 0);
    chk("badpid_state", 88'(dbg_state), 88'(ST_DRAIN));
    send_bits(88'hA5, 8, 0);
    send_eop();
    chk("badpid_idle", 88'(busy), 88'd0);

    // Truncated token.
    exp_q.push_back({3'd0, 88'd0});
    send_sync();
    send_bits(88'hE10A2, 20, 0);
    send_eop();
    chk("trunc_idle", 88'(busy), 88'd0);

    // Overlength handshake.
    exp_q.push_back({3'd0, 88'd0});
    send_sync();
    send_bits(88'hD2, 8, 0);
    send_bit(1'b1);
    tick();
    chk("overlen_state", 88'(dbg_state), 88'(ST_DRAIN));
    send_eop();
    chk("overlen_idle", 88'(busy), 88'd0);

    // Sync hunting through noise.
    exp_q.push_back({3'd3, 88'h1E});
    send_bits(88'h55, 8, 0);
    chk("noise_no_sync", 88'(busy), 88'd0);
    send_sync();
    send_bits(88'h1E, 8, 0);
    send_eop();
    take_pkt("hunt");

    // The SYNC-completing bit coincides with eop and must be dropped.
    send_bits(88'h00, 7, 0);
    s_in    = 1'b1;
    s_valid = 1'b1;
    eop     = 1'b1;
    tick();
    s_valid = 1'b0;
    eop     = 1'b0;
    chk("eop_drop_idle", 88'(busy), 88'd0);
    send_bits(88'hD2, 8, 0);
    send_eop();
    chk("eop_drop_no_pkt", {pkt_valid, busy}, 88'd0);

    // Reset in the middle of a data body.
    send_sync();
    send_bits({8'hC3, 24'h012345}, 32, 0);
    chk("mid_body_busy", 88'(busy), 88'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {pkt_valid, pkt_type, hshake, token, pkt_err, busy}, 88'd0);
    chk("midrst_data", data, 88'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({3'd3, 88'h5A});
    send_sync();
    send_bits(88'h5A, 8, 0);
    send_eop();
    take_pkt("nak");

    repeat (5) tick();
    chk("scoreboard_drained", 88'(exp_q.size()), 88'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
